// File: rtl/div.sv
// Sequential restoring divider: 16-bit dividend / 8-bit divisor, one quotient bit per clock.
// Shares the start/busy handshake of the shift-add multiplier.
module div (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] a_bi,
    input  logic [7:0]  b_bi,
    input  logic        start_i,
    output logic        busy_o,
    output logic [15:0] q_bo,
    output logic [7:0]  r_bo,
    output logic        dz_o
);

    localparam int unsigned AW = 16;
    localparam int unsigned BW = 8;
    localparam int unsigned RW = BW + 1;
    localparam int unsigned CW = 4;

    typedef enum logic {
        IDLE = 1'b0,
        WORK = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   dvd_q, dvd_d;
    logic [BW-1:0]   dvs_q, dvs_d;
    logic [RW-1:0]   rem_q, rem_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   qsr_q, qsr_d;
    logic [AW-1:0]   q_q, q_d;
    logic [BW-1:0]   r_q, r_d;
    logic            dz_q, dz_d;

    logic [RW-1:0]   shifted;
    logic [RW:0]     diff;
    logic            qbit;
    logic [AW-1:0]   qnext;

    // State and datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            qsr_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            qsr_q   <= qsr_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dz_q    <= dz_d;
        end
    end

    // Next-state and restoring-step logic
    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        qsr_d   = qsr_q;
        q_d     = q_q;
        r_d     = r_q;
        dz_d    = dz_q;

        // Extra top bit of diff acts as the borrow out of the 9-bit trial subtraction
        shifted = {rem_q[BW-1:0], dvd_q[AW-1]};
        diff    = {1'b0, shifted} - {2'b00, dvs_q};
        qbit    = ~diff[RW];
        qnext   = {qsr_q[AW-2:0], qbit};

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    dvd_d   = a_bi;
                    dvs_d   = b_bi;
                    rem_d   = '0;
                    cnt_d   = '0;
                    qsr_d   = '0;
                    state_d = WORK;
                end
            end
            WORK: begin
                rem_d = qbit ? diff[RW-1:0] : shifted;
                qsr_d = qnext;
                dvd_d = {dvd_q[AW-2:0], 1'b0};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(AW - 1)) begin
                    state_d = IDLE;
                    if (dvs_q == '0) begin
                        q_d  = '1;
                        r_d  = '0;
                        dz_d = 1'b1;
                    end else begin
                        q_d  = qnext;
                        r_d  = rem_d[BW-1:0];
                        dz_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_o = (state_q == WORK);
    assign q_bo   = q_q;
    assign r_bo   = r_q;
    assign dz_o   = dz_q;

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: directed table, handshake/reset sequences and
// randomized operands checked against plain integer division.
module tb_div;

    logic        clk_i;
    logic        rst_i;
    logic [15:0] a_bi;
    logic [7:0]  b_bi;
    logic        start_i;
    logic        busy_o;
    logic [15:0] q_bo;
    logic [7:0]  r_bo;
    logic        dz_o;

    int errors;
    int checks;

    div dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .a_bi    (a_bi),
        .b_bi    (b_bi),
        .start_i (start_i),
        .busy_o  (busy_o),
        .q_bo    (q_bo),
        .r_bo    (r_bo),
        .dz_o    (dz_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  b;
        logic [15:0] q;
        logic [7:0]  r;
        logic        dz;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Pulse start with the operands, then count busy cycles (bounded)
    task automatic do_op(input logic [15:0] a, input logic [7:0] b, output int busy_cycles);
        @(negedge clk_i);
        a_bi    = a;
        b_bi    = b;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        a_bi    = 16'($urandom);
        b_bi    = 8'($urandom);
        busy_cycles = 0;
        while (busy_o && busy_cycles < 40) begin
            busy_cycles++;
            @(negedge clk_i);
        end
    endtask

    vec_t tbl[$];

    initial begin
        int          n;
        int          n2;
        int          idle;
        logic [15:0] ra;
        logic [7:0]  rb;
        logic [15:0] prev_q;
        logic [7:0]  prev_r;
        logic        stable_ok;

        errors  = 0;
        checks  = 0;
        rst_i   = 1'b1;
        start_i = 1'b0;
        a_bi    = '0;
        b_bi    = '0;

        tbl.push_back('{16'd1000,  8'd7,   16'd142,   8'd6,  1'b0});
        tbl.push_back('{16'hFFFF,  8'd1,   16'hFFFF,  8'd0,  1'b0});
        tbl.push_back('{16'hFFFF,  8'hFF,  16'h0101,  8'd0,  1'b0});
        tbl.push_back('{16'd5,     8'd200, 16'd0,     8'd5,  1'b0});
        tbl.push_back('{16'd0,     8'd3,   16'd0,     8'd0,  1'b0});
        tbl.push_back('{16'h1234,  8'd0,   16'hFFFF,  8'h00, 1'b1});
        tbl.push_back('{16'd100,   8'd10,  16'd10,    8'd0,  1'b0});

        repeat (2) @(negedge clk_i);
        chk("reset_busy", 32'(busy_o), 32'd0);
        chk("reset_q",    32'(q_bo),   32'd0);
        chk("reset_r",    32'(r_bo),   32'd0);
        chk("reset_dz",   32'(dz_o),   32'd0);
        rst_i = 1'b0;

        foreach (tbl[i]) begin
            do_op(tbl[i].a, tbl[i].b, n);
            chk($sformatf("tbl%0d_latency", i), 32'(n), 32'd16);
            chk($sformatf("tbl%0d_q", i),  32'(q_bo), 32'(tbl[i].q));
            chk($sformatf("tbl%0d_r", i),  32'(r_bo), 32'(tbl[i].r));
            chk($sformatf("tbl%0d_dz", i), 32'(dz_o), 32'(tbl[i].dz));
        end

        // Start pulses during WORK are ignored; outputs hold the previous result
        prev_q = q_bo;
        prev_r = r_bo;
        stable_ok = 1'b1;
        @(negedge clk_i);
        a_bi = 16'hABCD; b_bi = 8'h13; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        n = 0;
        while (busy_o && n < 40) begin
            n++;
            if (q_bo !== prev_q || r_bo !== prev_r) stable_ok = 1'b0;
            if (n == 3 || n == 16) begin
                start_i = 1'b1; a_bi = 16'd7; b_bi = 8'd2;
            end else begin
                start_i = 1'b0;
            end
            @(negedge clk_i);
        end
        start_i = 1'b0;
        chk("hs_latency", 32'(n), 32'd16);
        chk("hs_stable",  32'(stable_ok), 32'd1);
        chk("hs_q",  32'(q_bo), 32'h090A);
        chk("hs_r",  32'(r_bo), 32'h0F);
        @(negedge clk_i);
        chk("hs_no_restart", 32'(busy_o), 32'd0);

        // start held high: exactly one idle cycle between back-to-back operations
        @(negedge clk_i);
        a_bi = 16'd300; b_bi = 8'd16; start_i = 1'b1;
        @(negedge clk_i);
        a_bi = 16'd1000; b_bi = 8'd7;
        n = 0;
        while (busy_o && n < 40) begin n++; @(negedge clk_i); end
        chk("held_lat1", 32'(n), 32'd16);
        chk("held_q1", 32'(q_bo), 32'd18);
        chk("held_r1", 32'(r_bo), 32'd12);
        idle = 0;
        while (!busy_o && idle < 40) begin idle++; @(negedge clk_i); end
        start_i = 1'b0;
        chk("held_idle", 32'(idle), 32'd1);
        n2 = 0;
        while (busy_o && n2 < 40) begin n2++; @(negedge clk_i); end
        chk("held_lat2", 32'(n2), 32'd16);
        chk("held_q2", 32'(q_bo), 32'd142);
        chk("held_r2", 32'(r_bo), 32'd6);

        // Reset in the middle of WORK clears everything
        do_op(16'h4321, 8'd0, n);
        chk("pre_rst_dz", 32'(dz_o), 32'd1);
        @(negedge clk_i);
        a_bi = 16'hFFFF; b_bi = 8'd3; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (7) @(negedge clk_i);
        chk("mid_busy", 32'(busy_o), 32'd1);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_q",    32'(q_bo),   32'd0);
        chk("rst_r",    32'(r_bo),   32'd0);
        chk("rst_dz",   32'(dz_o),   32'd0);
        repeat (3) @(negedge clk_i);
        chk("rst_stays_idle", 32'(busy_o), 32'd0);
        chk("rst_q_hold", 32'(q_bo), 32'd0);
        do_op(16'd300, 8'd16, n);
        chk("post_rst_lat", 32'(n), 32'd16);
        chk("post_rst_q", 32'(q_bo), 32'd18);
        chk("post_rst_r", 32'(r_bo), 32'd12);

        // Random operands against integer division
        for (int k = 0; k < 1000; k++) begin
            ra = 16'($urandom_range(0, 65535));
            rb = 8'($urandom_range(1, 255));
            do_op(ra, rb, n);
            chk("rnd_latency", 32'(n), 32'd16);
            chk("rnd_q",  32'(q_bo), 32'(ra) / 32'(rb));
            chk("rnd_r",  32'(r_bo), 32'(ra) % 32'(rb));
            chk("rnd_dz", 32'(dz_o), 32'd0);
            chk("rnd_inv", 32'(q_bo) * 32'(rb) + 32'(r_bo), 32'(ra));
            if (k % 100 == 0) begin
                do_op(16'($urandom), 8'd0, n);
                chk("rnd_dz_q",  32'(q_bo), 32'hFFFF);
                chk("rnd_dz_r",  32'(r_bo), 32'h0);
                chk("rnd_dz_dz", 32'(dz_o), 32'd1);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
